// File: rtl/cache_arb_pkg.sv
// Shared constants for the cache fill arbiter: geometry, FSM state codes,
// grant encodings and the block-offset mask helper.
package cache_arb_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int BLK_WORDS = 8;
    localparam int WORD_W    = $clog2(BLK_WORDS);
    localparam int CNT_W     = WORD_W + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IC   = 2'b01;
    localparam logic [1:0] GNT_DC   = 2'b10;

    // Byte-offset bits inside one block (words are 2 bytes wide).
    function automatic logic [ADDR_W-1:0] offsetMask();
        return ADDR_W'(2 * BLK_WORDS - 1);
    endfunction

endpackage

// File: rtl/cache_fill_arbiter_block_fill_seq.sv
// Block fill sequencer: issues BLK_WORDS pipelined reads from a base address
// and counts returned words, flagging the last one.
module block_fill_seq
    import cache_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              active,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic              dataValid,
    output logic              memEn,
    output logic [ADDR_W-1:0] memAddr,
    output logic              recvFire,
    output logic [WORD_W-1:0] recvWord,
    output logic              lastWord
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLK_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] issueCnt;
    logic [CNT_W-1:0] recvCnt;

    assign memEn    = active && (issueCnt < CNT_FULL);
    assign memAddr  = baseAddr + (ADDR_W'(issueCnt) << 1);
    // Responses beyond the block length are dropped here.
    assign recvFire = active && dataValid && (recvCnt < CNT_FULL);
    assign recvWord = recvCnt[WORD_W-1:0];
    assign lastWord = recvFire && (recvCnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issueCnt <= '0;
            recvCnt  <= '0;
        end else if (!active) begin
            issueCnt <= '0;
            recvCnt  <= '0;
        end else begin
            if (memEn) begin
                issueCnt <= issueCnt + CNT_ONE;
            end
            if (recvFire) begin
                recvCnt <= recvCnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares the main-memory read port between I-cache and D-cache block fills.
// Define ARB_RR_EN for round-robin arbitration; default is D-cache priority.
//
// state | meaning
// IDLE  | no fill in progress; arbitrate pending misses
// FILL  | issuing reads and steering returned words to the granted cache
// DONE  | one-cycle fill_done pulse to the granted cache
module cache_fill_arbiter
    import cache_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_miss,
    input  logic [ADDR_W-1:0] ic_miss_addr,
    output logic              ic_fill_we,
    output logic [WORD_W-1:0] ic_fill_word,
    output logic [DATA_W-1:0] ic_fill_data,
    output logic              ic_fill_done,
    input  logic              dc_miss,
    input  logic [ADDR_W-1:0] dc_miss_addr,
    output logic              dc_fill_we,
    output logic [WORD_W-1:0] dc_fill_word,
    output logic [DATA_W-1:0] dc_fill_data,
    output logic              dc_fill_done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic [1:0]        grant
);

    logic [1:0]        state;
    logic [1:0]        nextGrant;
    logic [ADDR_W-1:0] baseAddr;
    logic [ADDR_W-1:0] missAddr;
`ifdef ARB_RR_EN
    logic [1:0]        lastGrant;
`endif

    logic              seqMemEn;
    logic [ADDR_W-1:0] seqAddr;
    logic              recvFire;
    logic [WORD_W-1:0] recvWord;
    logic              lastWord;
    logic              icWe;
    logic              dcWe;

    always_comb begin
        nextGrant = GNT_NONE;
        if (ic_miss && dc_miss) begin
`ifdef ARB_RR_EN
            nextGrant = (lastGrant == GNT_DC) ? GNT_IC : GNT_DC;
`else
            nextGrant = GNT_DC;
`endif
        end else if (dc_miss) begin
            nextGrant = GNT_DC;
        end else if (ic_miss) begin
            nextGrant = GNT_IC;
        end
    end

    assign missAddr = (nextGrant == GNT_DC) ? dc_miss_addr : ic_miss_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= GNT_NONE;
            baseAddr <= '0;
`ifdef ARB_RR_EN
            lastGrant <= GNT_IC;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (nextGrant != GNT_NONE) begin
                        grant    <= nextGrant;
                        baseAddr <= missAddr & ~offsetMask();
                        state    <= FILL;
`ifdef ARB_RR_EN
                        lastGrant <= nextGrant;
`endif
                    end
                end
                FILL: begin
                    if (lastWord) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    grant <= GNT_NONE;
                end
                default: begin
                    state <= IDLE;
                    grant <= GNT_NONE;
                end
            endcase
        end
    end

    block_fill_seq u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (state == FILL),
        .baseAddr  (baseAddr),
        .dataValid (mem_data_valid),
        .memEn     (seqMemEn),
        .memAddr   (seqAddr),
        .recvFire  (recvFire),
        .recvWord  (recvWord),
        .lastWord  (lastWord)
    );

    assign busy     = (state != IDLE);
    assign mem_en   = seqMemEn;
    assign mem_addr = seqMemEn ? seqAddr : '0;

    assign icWe = recvFire && (grant == GNT_IC);
    assign dcWe = recvFire && (grant == GNT_DC);

    assign ic_fill_we   = icWe;
    assign ic_fill_word = icWe ? recvWord : '0;
    assign ic_fill_data = icWe ? mem_data : '0;
    assign ic_fill_done = (state == DONE) && (grant == GNT_IC);

    assign dc_fill_we   = dcWe;
    assign dc_fill_word = dcWe ? recvWord : '0;
    assign dc_fill_data = dcWe ? mem_data : '0;
    assign dc_fill_done = (state == DONE) && (grant == GNT_DC);

endmodule
